// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: default widths,
// read-latency limits and the sequencer state encoding.
package ram_arb_pkg;

  localparam int AW_DEF     = 4;
  localparam int DW_DEF     = 8;
  localparam int RD_LAT_DEF = 1;
  localparam int RD_LAT_MAX = 3;

  // Wide enough to hold RD_LAT_MAX-1, the largest wait count loaded.
  localparam int CNT_W      = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RDWAIT = 2'd2
  } state_t;

  // Wait count loaded on entry to RDWAIT. The final RDWAIT cycle is count 0.
  function automatic logic [CNT_W-1:0] rd_wait_init(input int rd_lat);
    return CNT_W'(rd_lat - 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. i_rr_ptr names the port that wins a tie;
// a lone request always wins. Output is one-hot, or zero when idle.
module rr_arb2 (
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_rr_ptr,
  output logic [1:0] o_sel
);

  // Resolve a tie with the priority pointer, otherwise pass the request through.
  always_comb begin
    o_sel = 2'b00;
    if (i_req0 && i_req1) begin
      o_sel = i_rr_ptr ? 2'b10 : 2'b01;
    end else begin
      o_sel = {i_req1, i_req0};
    end
  end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Round-robin arbiter and sequencer sharing one single-port RAM between
// two requesters. One access per grant: IDLE samples requests, ACCESS drives
// the RAM for exactly one cycle, RDWAIT covers the RAM read latency and
// captures the returned word into the shared rdata register.
//
// Handshake: a requester holds req (with we/addr/wdata) until it sees its
// gnt pulse; only the values present at the IDLE sampling edge are used.
// rvalid0/rvalid1 are single-cycle pulses qualifying the shared rdata, which
// holds its value until the next read capture. RD_LAT must be 1..RD_LAT_MAX.
module ram_arbiter_2p
  import ram_arb_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int DW     = DW_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_dout,
  output logic [1:0]    dbg_state
);

  state_t           r_state;
  state_t           w_nxt_state;
  logic             r_rr_ptr;
  logic             r_sel;
  logic             r_we;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_rdata;
  logic             r_rvalid0;
  logic             r_rvalid1;

  logic [1:0]       w_pick;
  logic             w_req_any;
  logic             w_rd_done;

  assign w_req_any = req0 | req1;
  assign w_rd_done = (r_state == ST_RDWAIT) && (r_cnt == '0);

  rr_arb2 u_rr_arb2 (
    .i_req0   (req0),
    .i_req1   (req1),
    .i_rr_ptr (r_rr_ptr),
    .o_sel    (w_pick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  // Next-state: one ACCESS per grant, writes return straight to IDLE.
  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_req_any) w_nxt_state = ST_ACCESS;
      ST_ACCESS: w_nxt_state = r_we ? ST_IDLE : ST_RDWAIT;
      ST_RDWAIT: if (r_cnt == '0) w_nxt_state = ST_IDLE;
      default:   w_nxt_state = ST_IDLE;
    endcase
  end

  // Transfer registers: latch the winner's command in IDLE, advance the
  // priority pointer in ACCESS, count down the read latency in RDWAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= 1'b0;
      r_sel    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_sel   <= w_pick[1];
            r_we    <= w_pick[1] ? we1    : we0;
            r_addr  <= w_pick[1] ? addr1  : addr0;
            r_wdata <= w_pick[1] ? wdata1 : wdata0;
          end
        end
        ST_ACCESS: begin
          r_rr_ptr <= ~r_sel;
          if (!r_we) r_cnt <= rd_wait_init(RD_LAT);
        end
        ST_RDWAIT: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Read return: capture RAM output at the end of the last RDWAIT cycle and
  // pulse rvalid for the issuing port in the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata   <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      if (w_rd_done) begin
        r_rdata   <= ram_dout;
        r_rvalid0 <= ~r_sel;
        r_rvalid1 <= r_sel;
      end
    end
  end

  // Outputs decoded from state: RAM pins are quiet outside ACCESS/RDWAIT.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (r_state)
      ST_ACCESS: begin
        gnt0      = ~r_sel;
        gnt1      = r_sel;
        ram_we    = r_we;
        ram_addr  = r_addr;
        ram_wdata = r_we ? r_wdata : '0;
      end
      ST_RDWAIT: begin
        ram_addr  = r_addr;
      end
      default: ;
    endcase
  end

  assign busy      = (r_state != ST_IDLE);
  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata     = r_rdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Bench for ram_arbiter_2p: a RD_LAT=1 instance driven by directed and random
// requests and checked cycle-by-cycle against a transaction-level model, plus
// a RD_LAT=3 instance exercised with a directed timing check.
module tb_ram_arbiter_2p;

  localparam int AW      = 4;
  localparam int DW      = 8;
  localparam int RD_LAT  = 1;
  localparam int RD_LAT3 = 3;
  localparam int TIMEOUT = 200;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (RD_LAT=1) ----------------
  logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy, ram_we;
  logic [DW-1:0] rdata, ram_wdata, ram_dout;
  logic [AW-1:0] ram_addr;
  logic [1:0]    dbg_state;

  ram_arbiter_2p #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_dout(ram_dout), .dbg_state(dbg_state)
  );

  // Environment RAM, one-cycle synchronous read.
  logic [DW-1:0] ram_mem [16];
  logic [DW-1:0] ram_q;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_q <= ram_mem[ram_addr];
  end
  assign ram_dout = ram_q;

  // ---------------- second DUT (RD_LAT=3) ----------------
  logic          t3_req0 = 0, t3_req1 = 0, t3_we0 = 0, t3_we1 = 0;
  logic [AW-1:0] t3_addr0 = '0, t3_addr1 = '0;
  logic [DW-1:0] t3_wdata0 = '0, t3_wdata1 = '0;
  logic          t3_gnt0, t3_gnt1, t3_rvalid0, t3_rvalid1, t3_busy, t3_ram_we;
  logic [DW-1:0] t3_rdata, t3_ram_wdata, t3_ram_dout;
  logic [AW-1:0] t3_ram_addr;
  logic [1:0]    t3_dbg_state;

  ram_arbiter_2p #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0(t3_req0), .req1(t3_req1), .we0(t3_we0), .we1(t3_we1),
    .addr0(t3_addr0), .addr1(t3_addr1), .wdata0(t3_wdata0), .wdata1(t3_wdata1),
    .gnt0(t3_gnt0), .gnt1(t3_gnt1), .rvalid0(t3_rvalid0), .rvalid1(t3_rvalid1),
    .rdata(t3_rdata), .busy(t3_busy),
    .ram_we(t3_ram_we), .ram_addr(t3_ram_addr), .ram_wdata(t3_ram_wdata),
    .ram_dout(t3_ram_dout), .dbg_state(t3_dbg_state)
  );

  // Environment RAM with a three-stage read pipeline.
  logic [DW-1:0] t3_mem [16];
  logic [DW-1:0] t3_p1, t3_p2, t3_p3;
  always @(posedge clk) begin
    if (t3_ram_we) t3_mem[t3_ram_addr] <= t3_ram_wdata;
    t3_p1 <= t3_mem[t3_ram_addr];
    t3_p2 <= t3_p1;
    t3_p3 <= t3_p2;
  end
  assign t3_ram_dout = t3_p3;

  // ---------------- check helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic chk_v(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard monitor ----------------
  typedef struct {
    int            port;
    logic [DW-1:0] data;
    int            cyc;
    logic [AW-1:0] addr;
  } rd_t;

  rd_t           rd_q [$];
  logic [DW-1:0] model_mem [16];
  logic          prio      = 1'b0;   // port that wins a tie
  logic          idle_prev = 1'b0;   // arbiter was idle in the previous cycle
  logic [DW-1:0] last_rdata = '0;
  logic          s_req0 = 0, s_req1 = 0, s_we0 = 0, s_we1 = 0;
  logic [AW-1:0] s_addr0 = '0, s_addr1 = '0;
  logic [DW-1:0] s_wdata0 = '0, s_wdata1 = '0;

  logic [1:0]    m_g;
  logic          m_pend, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_port;
  rd_t           m_rd;

  // Sampled mid-cycle. The previous negedge snapshot holds the request
  // values the arbiter saw at the intervening rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_q.delete();
      prio       = 1'b0;
      idle_prev  = 1'b0;
      last_rdata = '0;
    end else begin
      m_g = 2'b00;
      if (idle_prev && (s_req0 || s_req1)) begin
        if (s_req0 && s_req1) m_g = prio ? 2'b10 : 2'b01;
        else                  m_g = {s_req1, s_req0};
      end
      chk_b("gnt0", gnt0, m_g[0]);
      chk_b("gnt1", gnt1, m_g[1]);

      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        m_rd = rd_q.pop_front();
        chk_b("rvalid0", rvalid0, m_rd.port == 0);
        chk_b("rvalid1", rvalid1, m_rd.port == 1);
        chk_v("rdata", 32'(rdata), 32'(m_rd.data));
        last_rdata = m_rd.data;
      end else begin
        chk_b("rvalid0_idle", rvalid0, 1'b0);
        chk_b("rvalid1_idle", rvalid1, 1'b0);
        chk_v("rdata_hold", 32'(rdata), 32'(last_rdata));
      end

      m_pend = (rd_q.size() > 0) && (cyc < rd_q[0].cyc);

      if (m_g != 2'b00) begin
        m_port  = m_g[1] ? 1 : 0;
        m_we    = m_g[1] ? s_we1    : s_we0;
        m_addr  = m_g[1] ? s_addr1  : s_addr0;
        m_wdata = m_g[1] ? s_wdata1 : s_wdata0;
        chk_b("ram_we_access", ram_we, m_we);
        chk_v("ram_addr_access", 32'(ram_addr), 32'(m_addr));
        chk_v("ram_wdata_access", 32'(ram_wdata), m_we ? 32'(m_wdata) : 32'd0);
        if (m_we) begin
          model_mem[m_addr] = m_wdata;
        end else begin
          m_rd.port = m_port;
          m_rd.data = model_mem[m_addr];
          m_rd.cyc  = cyc + 1 + RD_LAT;
          m_rd.addr = m_addr;
          rd_q.push_back(m_rd);
        end
        prio = ~m_g[1];
      end else if (m_pend) begin
        chk_b("ram_we_rdwait", ram_we, 1'b0);
        chk_v("ram_addr_rdwait", 32'(ram_addr), 32'(rd_q[0].addr));
        chk_v("ram_wdata_rdwait", 32'(ram_wdata), 32'd0);
      end else begin
        chk_b("ram_we_idle", ram_we, 1'b0);
        chk_v("ram_addr_idle", 32'(ram_addr), 32'd0);
        chk_v("ram_wdata_idle", 32'(ram_wdata), 32'd0);
      end
      chk_b("busy", busy, (m_g != 2'b00) || m_pend);
      idle_prev = (m_g == 2'b00) && !m_pend;
    end
    s_req0 = req0;  s_req1 = req1;
    s_we0 = we0;    s_we1 = we1;
    s_addr0 = addr0; s_addr1 = addr1;
    s_wdata0 = wdata0; s_wdata1 = wdata1;
  end

  // ---------------- driver tasks ----------------
  // Raise a request and hold it until granted. After chg waiting cycles
  // without a grant, the address and write data are swapped for a2/d2.
  task automatic issue(input int p, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int chg,
                       input logic [AW-1:0] a2, input logic [DW-1:0] d2);
    bit got;
    got = 0;
    if (p == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
    for (int k = 0; k < TIMEOUT; k++) begin
      @(posedge clk); #1;
      if ((p == 0) ? gnt0 : gnt1) begin
        got = 1;
        break;
      end
      if (k == chg) begin
        if (p == 0) begin addr0 = a2; wdata0 = d2; end
        else        begin addr1 = a2; wdata1 = d2; end
      end
    end
    chk_b("gnt_timeout", got, 1'b1);
    if (p == 0) req0 = 0;
    else        req1 = 0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rand_port(input int p, input int n);
    int chg;
    repeat (n) begin
      idle_cycles($urandom_range(0, 3));
      chg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
      issue(p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            8'($urandom_range(0, 255)), chg,
            4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk_b({tag, "_gnt0"}, gnt0, 1'b0);
    chk_b({tag, "_gnt1"}, gnt1, 1'b0);
    chk_b({tag, "_rvalid0"}, rvalid0, 1'b0);
    chk_b({tag, "_rvalid1"}, rvalid1, 1'b0);
    chk_b({tag, "_busy"}, busy, 1'b0);
    chk_b({tag, "_ram_we"}, ram_we, 1'b0);
    chk_v({tag, "_rdata"}, 32'(rdata), 32'd0);
    chk_v({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk_v({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    chk_v({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    checks++;
    errors++;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- main sequence ----------------
  int            e, gnt_e, rv_e, busy_n;
  bit            rv0_seen;
  logic [DW-1:0] cap;

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = '0; model_mem[i] = '0; t3_mem[i] = '0;
    end

    // Reset state.
    idle_cycles(3);
    check_all_zero("reset");
    chk_b("reset_t3_busy", t3_busy, 1'b0);
    chk_b("reset_t3_rvalid1", t3_rvalid1, 1'b0);
    rst_n = 1;
    idle_cycles(2);

    // Two writes, one per port.
    issue(0, 1'b1, 4'h0, 8'hAA, -1, 4'h0, 8'h00);
    issue(1, 1'b1, 4'h1, 8'h55, -1, 4'h0, 8'h00);
    idle_cycles(2);
    chk_v("ram_word0", 32'(ram_mem[0]), 32'hAA);
    chk_v("ram_word1", 32'(ram_mem[1]), 32'h55);

    // Reads back, one per port.
    issue(0, 1'b0, 4'h0, 8'h00, -1, 4'h0, 8'h00);
    issue(1, 1'b0, 4'h1, 8'h00, -1, 4'h0, 8'h00);
    idle_cycles(4);

    // Both requesters held back-to-back: grants must alternate.
    fork
      repeat (4) issue(0, 1'b1, 4'h2, 8'h11, -1, 4'h0, 8'h00);
      repeat (4) issue(1, 1'b1, 4'h3, 8'h22, -1, 4'h0, 8'h00);
    join
    idle_cycles(2);
    chk_v("ram_word2", 32'(ram_mem[2]), 32'h11);
    chk_v("ram_word3", 32'(ram_mem[3]), 32'h22);

    // Port0 changes its address while queued behind a port1 read.
    issue(0, 1'b1, 4'h5, 8'h5A, -1, 4'h0, 8'h00);
    fork
      issue(1, 1'b0, 4'h3, 8'h00, -1, 4'h0, 8'h00);
      begin
        idle_cycles(1);
        issue(0, 1'b0, 4'h4, 8'h00, 0, 4'h5, 8'h00);
      end
    join
    idle_cycles(4);

    // Reset in the middle of a port1 read.
    issue(1, 1'b0, 4'h1, 8'h00, -1, 4'h0, 8'h00);
    idle_cycles(1);
    #2 rst_n = 0;
    #1 check_all_zero("midreset");
    idle_cycles(2);
    rst_n = 1;
    idle_cycles(3);
    fork
      issue(0, 1'b0, 4'h0, 8'h00, -1, 4'h0, 8'h00);
      issue(1, 1'b0, 4'h1, 8'h00, -1, 4'h0, 8'h00);
    join
    idle_cycles(4);

    // Random traffic from both ports.
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    idle_cycles(6);
    chk_v("drain_reads", 32'(rd_q.size()), 32'd0);

    // RD_LAT=3 instance: write then read 0xF on port1.
    t3_req1 = 1; t3_we1 = 1; t3_addr1 = 4'hF; t3_wdata1 = 8'hC3;
    gnt_e = -1;
    for (int k = 1; k <= 20 && gnt_e < 0; k++) begin
      @(posedge clk); #1;
      if (t3_gnt1) gnt_e = k;
    end
    t3_req1 = 0;
    chk_v("t3_write_gnt", 32'(gnt_e), 32'd1);
    idle_cycles(2);
    chk_v("t3_ram_wordF", 32'(t3_mem[15]), 32'hC3);

    t3_req1 = 1; t3_we1 = 0; t3_wdata1 = 8'h00;
    gnt_e = -1; rv_e = -1; busy_n = 0; rv0_seen = 0; cap = '0;
    for (e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      if (t3_gnt1 && gnt_e < 0) begin gnt_e = e; t3_req1 = 0; end
      if (t3_busy) busy_n++;
      if (t3_rvalid0) rv0_seen = 1;
      if (t3_rvalid1 && rv_e < 0) begin rv_e = e; cap = t3_rdata; end
    end
    chk_v("t3_read_gnt_cycle", 32'(gnt_e), 32'd1);
    chk_v("t3_rvalid1_cycle", 32'(rv_e), 32'd5);
    chk_v("t3_rdata", 32'(cap), 32'hC3);
    chk_v("t3_busy_cycles", 32'(busy_n), 32'd4);
    chk_b("t3_no_rvalid0", rv0_seen, 1'b0);
    chk_v("t3_rdata_hold", 32'(t3_rdata), 32'hC3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
